// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request/result bus between requesters and the shared adder.
interface adder_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [W:0]        res_sum;
    logic [IW-1:0]     res_id;
    logic              res_ready;
    logic              busy;
    logic [7:0]        op_count;
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id, busy, op_count
    );
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id, busy, op_count
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one registered W-bit adder among NREQ requesters.
module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input logic             clk,
    input logic             reset,
    adder_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic [IW-1:0] nxt_ptr;
    logic          found;
    logic          grant;
    int            j;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [IW-1:0] id_q;
    logic          res_valid_q;
    logic [W:0]    res_sum_q;
    logic [IW-1:0] res_id_q;
    logic          busy_q;
    logic [7:0]    op_count_q;
    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            cand = IW'(j);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
    assign grant   = (state == IDLE) && found && !reset;
    assign nxt_ptr = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    assign bus.req_ready = grant ? (NREQ'(1) << win) : '0;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = op_count_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    a_q    <= bus.req_a[win*W +: W];
                    b_q    <= bus.req_b[win*W +: W];
                    id_q   <= win;
                    rr_ptr <= nxt_ptr;
                    busy_q <= 1'b1;
                    state  <= CALC;
                end
                CALC: begin
                    res_sum_q   <= {1'b0, a_q} + {1'b0, b_q};
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    op_count_q  <= op_count_q + 8'd1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed-vector bench for adder_arbiter with NREQ=4, W=4.
module tb_adder_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [4:0] fair_sum [4] = '{5'h07, 5'h0A, 5'h0D, 5'h10};
    always #5 clk = ~clk;
    adder_arbiter_if #(.NREQ(4), .W(4)) bus ();
    adder_arbiter #(.NREQ(4), .W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 0);
        check({tag, "_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_sum"}, 32'(bus.res_sum), 0);
        check({tag, "_id"}, 32'(bus.res_id), 0);
        check({tag, "_cnt"}, 32'(bus.op_count), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask
    // Starts in IDLE, ends in the first DONE cycle.
    task automatic op(input logic [3:0] vld, input logic [15:0] a, input logic [15:0] b,
                      input int id, input logic [4:0] sum);
        bus.req_valid = vld;
        bus.req_a = a;
        bus.req_b = b;
        #1;
        check("grant", 32'(bus.req_ready), 32'(1 << id));
        check("idle_busy", 32'(bus.busy), 0);
        tick();
        check("calc_ready", 32'(bus.req_ready), 0);
        check("calc_busy", 32'(bus.busy), 1);
        check("calc_valid", 32'(bus.res_valid), 0);
        tick();
        check("done_valid", 32'(bus.res_valid), 1);
        check("done_sum", 32'(bus.res_sum), 32'(sum));
        check("done_id", 32'(bus.res_id), 32'(id));
        check("done_ready", 32'(bus.req_ready), 0);
    endtask
    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = 1'b1;
        #1 reset = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        check_zero("rst");
        bus.req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        check("idle_valid0", 32'(bus.res_valid), 0);
        op(4'b0001, 16'h0007, 16'h0005, 0, 5'h0C);
        bus.req_valid = '0;
        tick();
        check("cnt1", 32'(bus.op_count), 1);
        check("after_valid", 32'(bus.res_valid), 0);
        check("after_busy", 32'(bus.busy), 0);
        op(4'b0100, 16'h0F00, 16'h0F00, 2, 5'h1E);
        bus.req_valid = '0;
        tick();
        check("cnt2", 32'(bus.op_count), 2);
        reset = 1'b1;
        #1;
        check_zero("rst2");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op(4'hF, 16'h4321, 16'hCA86, i % 4, fair_sum[i % 4]);
            tick();
            check("fair_cnt", 32'(bus.op_count), 32'(i + 1));
        end
        bus.res_ready = 1'b0;
        op(4'b1000, 16'h9000, 16'h3000, 3, 5'h0C);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(bus.res_valid), 1);
            check("bp_sum", 32'(bus.res_sum), 32'h0C);
            check("bp_id", 32'(bus.res_id), 3);
            check("bp_ready", 32'(bus.req_ready), 0);
            check("bp_busy", 32'(bus.busy), 1);
        end
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        tick();
        check("bp_rel_busy", 32'(bus.busy), 0);
        check("bp_rel_valid", 32'(bus.res_valid), 0);
        check("bp_cnt", 32'(bus.op_count), 6);
        bus.req_valid = 4'b1000;
        bus.req_a = 16'h1000;
        bus.req_b = 16'h1000;
        #1;
        check("mid_grant", 32'(bus.req_ready), 32'h8);
        tick();
        check("mid_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        bus.req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", 32'(bus.res_valid), 0);
        end
        op(4'b1010, 16'h0020, 16'h0030, 1, 5'h05);
        bus.req_valid = '0;
        tick();
        check("post_rst_cnt", 32'(bus.op_count), 1);
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 255; i++) begin
            tick();
            tick();
            tick();
        end
        check("wrap_255", 32'(bus.op_count), 255);
        tick();
        tick();
        tick();
        check("wrap_0", 32'(bus.op_count), 0);
        bus.req_valid = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter W, default 4, operand width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W].
REQ-007 req_b  input  NREQ*W  operand B, same packing as req_a.
REQ-008 req_ready  output  NREQ  per-requester grant/accept, at most one bit high.
REQ-009 res_valid  output  1  result valid.
REQ-010 res_sum  output  W+1  registered sum including carry-out.
REQ-011 res_id  output  clog2(NREQ)  index of requester owning res_sum.
REQ-012 res_ready  input  1  downstream accepts result.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 op_count  output  8  number of completed result transfers, wraps 255->0.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-016 IDLE: if any req_valid bit is set, the arbiter SHALL assert req_ready for exactly one winner in the same cycle (combinational from req_valid and pointer), latch that requester's A, B and index, and go to CALC.
REQ-017 IDLE with no req_valid: req_ready all zero, remain in IDLE.
REQ-018 Winner selection SHALL be round-robin: search starts at index rr_ptr and proceeds upward modulo NREQ; first set req_valid bit wins.
REQ-019 On every grant rr_ptr SHALL become (winner+1) mod NREQ; rr_ptr unchanged when no grant.
REQ-020 A transfer on requester i SHALL occur only in a cycle with req_valid[i] and req_ready[i] both high.
REQ-021 req_ready SHALL be all zero in CALC and DONE.
REQ-022 CALC: res_sum SHALL be loaded with zero-extended A plus zero-extended B (W+1 bits, no truncation), res_id with latched index; next state DONE.
REQ-023 DONE: res_valid SHALL be high; res_sum and res_id SHALL hold stable until the transfer.
REQ-024 DONE with res_ready high: transfer completes, op_count increments by 1, next state IDLE, res_valid low next cycle.
REQ-025 DONE with res_ready low: remain in DONE indefinitely.
REQ-026 Latency: grant at cycle N gives res_valid high at cycle N+2; minimum issue interval 3 cycles.
REQ-027 Requests arriving while not IDLE SHALL be neither granted nor lost by the block; requesters keep req_valid asserted until granted.
REQ-028 Deasserting req_valid before grant SHALL withdraw the request with no side effect.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 Reset asserted SHALL immediately force state IDLE, rr_ptr 0, req_ready 0, res_valid 0, res_sum 0, res_id 0, op_count 0, busy 0.
REQ-031 Reset during CALC or DONE SHALL discard the in-flight operation; no result is delivered afterward.
REQ-032 After reset release, first grant SHALL follow REQ-018 with rr_ptr 0.

Verification
REQ-033 Single request: req_valid=0001, A0=4'h7, B0=4'h5, res_ready=1 -> req_ready=0001 at cycle N, res_valid at N+2 with res_sum=5'h0C, res_id=0, op_count=1.
REQ-034 Carry: A2=4'hF, B2=4'hF on requester 2 -> res_sum=5'h1E, res_id=2.
REQ-035 Fairness: req_valid=1111 held, res_ready=1 -> grants in order 0,1,2,3,0 every 3 cycles; each res_id matches.
REQ-036 Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_sum, res_id stable, req_ready=0, busy=1; res_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-op: assert reset during CALC -> all outputs 0 immediately, no res_valid after release; next grant with req_valid=1010 goes to requester 1.
REQ-038 Counter wrap: 256 completed transfers -> op_count returns to 0.
